// File: rtl/spi_slave_cmd_pkg.sv
// spi_slave_cmd_pkg: shared opcodes, command FSM state type and idle tx byte
// for the SPI slave command front-end (spi_slave_cmd_ctrl and its unpacker).
// Optional build macro: SPI_CMD_STATUS_EN (enables OPC_STATUS / ST_STATUS use).
package spi_slave_cmd_pkg;

  localparam logic [7:0] OPC_WRITE    = 8'h02;
  localparam logic [7:0] OPC_READ     = 8'h0B;
  localparam logic [7:0] OPC_SET_WRAP = 8'h11;
  localparam logic [7:0] OPC_STATUS   = 8'h05;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_WRAP,
    ST_IGNORE,
    ST_STATUS
  } cmd_state_e;

endpackage

// File: rtl/spi_slave_word_unpacker.sv
// spi_slave_word_unpacker: read-path byte buffer. Takes 32-bit words from the
// OBI plug and hands them out byte by byte, least significant byte first.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   active         command FSM is in RDATA
//   flush          chip select deasserted: drop buffered bytes
//   tx_data/valid  word from plug; tx_ready high when buffer is empty
//   tx_byte_req    shifter consumed tx_byte
//   tx_byte        current byte, TX_IDLE_BYTE when empty
//   underrun_clr   clears the sticky underrun flag
//   underrun       sticky: byte requested while buffer empty
module spi_slave_word_unpacker
  import spi_slave_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        flush,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_byte_req,
  output logic [7:0]  tx_byte,
  input  logic        underrun_clr,
  output logic        underrun
);

  logic [31:0] shift_buf;
  logic [2:0]  count;
  logic        empty;

  assign empty    = (count == 3'd0);
  assign tx_ready = active && !flush && empty;
  assign tx_byte  = empty ? TX_IDLE_BYTE : shift_buf[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_buf <= '0;
      count     <= '0;
      underrun  <= 1'b0;
    end else begin
      if (flush) begin
        shift_buf <= '0;
        count     <= '0;
      end else if (tx_valid && tx_ready) begin
        shift_buf <= tx_data;
        count     <= 3'd4;
      end else if (active && tx_byte_req && !empty) begin
        shift_buf <= {8'h00, shift_buf[31:8]};
        count     <= count - 3'd1;
      end

      if (underrun_clr) begin
        underrun <= 1'b0;
      end else if (active && !flush && tx_byte_req && empty) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_cmd_ctrl.sv
// spi_slave_cmd_ctrl: SPI slave command/data front-end. Parses each chip-select
// frame (opcode, 4-byte MSB-first address, dummy bytes, payload), loads the
// plug's address, starts reads, packs write bytes little-endian into 32-bit
// words and unpacks read words into bytes.
// Optional build macro: SPI_CMD_STATUS_EN adds opcode 8'h05 (READ_STATUS),
// which returns {6'b0, underrun, overflow} and clears both flags on the first
// byte request.
// Ports:
//   obi_aclk, obi_areset          clock, synchronous active-high reset
//   cs                            chip select, active low
//   rx_byte, rx_byte_valid        incoming SPI bytes
//   tx_byte, tx_byte_req          outgoing SPI bytes
//   rxtx_addr, rxtx_addr_valid    address load to plug
//   start_tx                      read start pulse
//   wrap_length                   wrap length in words
//   rx_data, rx_valid, rx_ready   write word to plug
//   tx_data, tx_valid, tx_ready   read word from plug
//   overflow, underrun            sticky error flags
module spi_slave_cmd_ctrl
  import spi_slave_cmd_pkg::*;
#(
  parameter int OBI_ADDR_WIDTH = 32,
  parameter int DUMMY_BYTES    = 1
) (
  input  logic                      obi_aclk,
  input  logic                      obi_areset,
  input  logic                      cs,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_byte_valid,
  output logic [7:0]                tx_byte,
  input  logic                      tx_byte_req,
  output logic [OBI_ADDR_WIDTH-1:0] rxtx_addr,
  output logic                      rxtx_addr_valid,
  output logic                      start_tx,
  output logic [15:0]               wrap_length,
  output logic [31:0]               rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [31:0]               tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      overflow,
  output logic                      underrun
);

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_BYTES - 1);

  cmd_state_e  state, state_next;
  logic [3:0]  cnt;
  logic        is_read;
  logic [23:0] addr_sr;
  logic [31:0] wbuf;
  logic [7:0]  wrap_hi;
  logic        start_pend;
  logic        status_clr;
  logic [7:0]  unpack_byte;

  logic        rxv;
  logic        addr_last, dummy_last, wdata_last, wrap_last;
  logic [31:0] addr_word;
  logic [31:0] word_done;

  // cs high overrides everything, including a coincident byte strobe
  assign rxv        = rx_byte_valid && !cs;
  assign addr_last  = (state == ST_ADDR)  && rxv && (cnt == 4'd3);
  assign dummy_last = (state == ST_DUMMY) && rxv && (cnt == DUMMY_LAST);
  assign wdata_last = (state == ST_WDATA) && rxv && (cnt == 4'd3);
  assign wrap_last  = (state == ST_WRAP)  && rxv && (cnt == 4'd1);
  assign addr_word  = {addr_sr, rx_byte};
  assign word_done  = {rx_byte, wbuf[31:8]};

  always_ff @(posedge obi_aclk) begin
    if (obi_areset) state <= ST_CMD;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs) begin
      state_next = ST_CMD;
    end else begin
      unique case (state)
        ST_CMD: begin
          if (rxv) begin
            case (rx_byte)
              OPC_WRITE, OPC_READ: state_next = ST_ADDR;
              OPC_SET_WRAP:        state_next = ST_WRAP;
`ifdef SPI_CMD_STATUS_EN
              OPC_STATUS:          state_next = ST_STATUS;
`endif
              default:             state_next = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (addr_last) begin
            if (!is_read)              state_next = ST_WDATA;
            else if (DUMMY_BYTES == 0) state_next = ST_RDATA;
            else                       state_next = ST_DUMMY;
          end
        end
        ST_DUMMY:  if (dummy_last) state_next = ST_RDATA;
        ST_WRAP:   if (wrap_last)  state_next = ST_IGNORE;
        ST_STATUS: if (tx_byte_req) state_next = ST_IGNORE;
        default:   state_next = state;
      endcase
    end
  end

`ifdef SPI_CMD_STATUS_EN
  assign status_clr = (state == ST_STATUS) && tx_byte_req && !cs;
  assign tx_byte    = (state == ST_STATUS) ? {6'b0, underrun, overflow} : unpack_byte;
`else
  assign status_clr = 1'b0;
  assign tx_byte    = unpack_byte;
`endif

  always_ff @(posedge obi_aclk) begin
    if (obi_areset) begin
      cnt             <= '0;
      is_read         <= 1'b0;
      addr_sr         <= '0;
      wbuf            <= '0;
      wrap_hi         <= '0;
      start_pend      <= 1'b0;
      rxtx_addr       <= '0;
      rxtx_addr_valid <= 1'b0;
      start_tx        <= 1'b0;
      wrap_length     <= '0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      // Byte counter restarts on every state change; WDATA wraps every word.
      if (cs || (state_next != state) || wdata_last) cnt <= '0;
      else if (rxv)                                    cnt <= cnt + 4'd1;

      if ((state == ST_CMD) && rxv) is_read <= (rx_byte == OPC_READ);
      if ((state == ST_ADDR) && rxv) addr_sr <= addr_word[23:0];
      if ((state == ST_WDATA) && rxv) wbuf <= word_done;
      if ((state == ST_WRAP) && rxv && (cnt == 4'd0)) wrap_hi <= rx_byte;
      if (wrap_last) wrap_length <= {wrap_hi, rx_byte};

      rxtx_addr_valid <= addr_last;
      if (addr_last) rxtx_addr <= addr_word[OBI_ADDR_WIDTH-1:0];

      // With no dummy bytes the start is delayed one extra cycle so it never
      // coincides with the address load pulse.
      start_pend <= addr_last && is_read && (DUMMY_BYTES == 0);
      start_tx   <= dummy_last || start_pend;

      // A held word survives cs; a new word only replaces it once it drains.
      if (wdata_last && (!rx_valid || rx_ready)) begin
        rx_data  <= word_done;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (status_clr)                             overflow <= 1'b0;
      else if (wdata_last && rx_valid && !rx_ready) overflow <= 1'b1;
    end
  end

  spi_slave_word_unpacker u_unpacker (
    .clk          (obi_aclk),
    .rst          (obi_areset),
    .active       (state == ST_RDATA),
    .flush        (cs),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_byte_req  (tx_byte_req),
    .tx_byte      (unpack_byte),
    .underrun_clr (status_clr),
    .underrun     (underrun)
  );

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// tb_spi_slave_cmd_ctrl: directed-sequence bench with randomized addresses and
// payloads for spi_slave_cmd_ctrl. Expected values come from the frame format
// (MSB-first address, little-endian payload words, LSB-first read bytes).
// Honors SPI_CMD_STATUS_EN when defined.
module tb_spi_slave_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_req;
  logic [31:0] rxtx_addr;
  logic        rxtx_addr_valid;
  logic        start_tx;
  logic [15:0] wrap_length;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  int av_cnt = 0, st_cnt = 0, coinc = 0, rxv_cycles = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic exp_overflow = 1'b0, exp_underrun = 1'b0;

  always #5 clk = ~clk;

  spi_slave_cmd_ctrl #(.OBI_ADDR_WIDTH(32), .DUMMY_BYTES(1)) dut (
    .obi_aclk        (clk),
    .obi_areset      (rst),
    .cs              (cs),
    .rx_byte         (rx_byte),
    .rx_byte_valid   (rx_byte_valid),
    .tx_byte         (tx_byte),
    .tx_byte_req     (tx_byte_req),
    .rxtx_addr       (rxtx_addr),
    .rxtx_addr_valid (rxtx_addr_valid),
    .start_tx        (start_tx),
    .wrap_length     (wrap_length),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .overflow        (overflow),
    .underrun        (underrun)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (rxtx_addr_valid) av_cnt++;
      if (start_tx) st_cnt++;
      if (start_tx && rxtx_addr_valid) coinc++;
      if (rx_valid) rxv_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_byte = b; rx_byte_valid = 1'b1;
    @(posedge clk); #1 rx_byte_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic cs_assert();
    @(posedge clk); #1 cs = 1'b0;
  endtask

  task automatic cs_release();
    @(posedge clk); #1 cs = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tx_req();
    @(posedge clk); #1 tx_byte_req = 1'b1;
    @(posedge clk); #1 tx_byte_req = 1'b0;
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] addr, word, w1, w2;
    logic [15:0] wl;
    int nw, av0, st0, rxv0;

    rst = 1'b1; cs = 1'b1; rx_byte = '0; rx_byte_valid = 1'b0;
    tx_byte_req = 1'b0; rx_ready = 1'b1; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_tx_byte", 32'(tx_byte), 32'hFF);
    chk("reset_addr_valid", 32'(rxtx_addr_valid), 0);
    chk("reset_start_tx", 32'(start_tx), 0);
    chk("reset_wrap", 32'(wrap_length), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_tx_ready", 32'(tx_ready), 0);
    chk("reset_flags", {30'b0, underrun, overflow}, 0);

    // Write frames: first is the reference frame, the rest randomized.
    for (int f = 0; f < 3; f++) begin
      addr = (f == 0) ? 32'h10000040 : $urandom;
      nw   = (f == 0) ? 1 : int'($urandom_range(1, 3));
      av0 = av_cnt; rxv0 = rxv_cycles;
      cs_assert();
      send_byte(8'h02);
      send_addr(addr);
      chk("wr_addr_valid", 32'(rxtx_addr_valid), 1);
      chk("wr_addr", rxtx_addr, addr);
      for (int w = 0; w < nw; w++) begin
        word = (f == 0) ? 32'hEFBEADDE : $urandom;
        exp_q.push_back(word);
        for (int b = 0; b < 4; b++) send_byte(word[8*b +: 8]);
        chk("wr_rx_valid", 32'(rx_valid), 1);
        chk("wr_rx_data", rx_data, word);
      end
      cs_release();
      chk("wr_rx_valid_fall", 32'(rx_valid), 0);
      chk("wr_addr_pulses", 32'(av_cnt - av0), 1);
      chk("wr_rx_valid_cycles", 32'(rxv_cycles - rxv0), 32'(nw));
      check_words("wr");
    end

    // Read frame: address, one dummy byte, two words, then an underrun.
    st0 = st_cnt;
    addr = $urandom;
    cs_assert();
    send_byte(8'h0B);
    send_addr(addr);
    chk("rd_addr_valid", 32'(rxtx_addr_valid), 1);
    chk("rd_addr", rxtx_addr, addr);
    chk("rd_no_early_start", 32'(start_tx), 0);
    send_byte(8'($urandom));
    chk("rd_start_tx", 32'(start_tx), 1);
    chk("rd_tx_ready", 32'(tx_ready), 1);
    for (int wi = 0; wi < 2; wi++) begin
      word = (wi == 0) ? 32'h44332211 : $urandom;
      chk("rd_ready_before_load", 32'(tx_ready), 1);
      @(posedge clk); #1 tx_data = word; tx_valid = 1'b1;
      @(posedge clk); #1 tx_valid = 1'b0;
      chk("rd_ready_after_load", 32'(tx_ready), 0);
      for (int b = 0; b < 4; b++) begin
        chk("rd_tx_byte", 32'(tx_byte), 32'(word[8*b +: 8]));
        tx_req();
      end
      chk("rd_new_word_req", 32'(tx_ready), 1);
    end
    chk("rd_no_underrun_yet", 32'(underrun), 0);
    tx_req();
    exp_underrun = 1'b1;
    chk("rd_underrun_byte", 32'(tx_byte), 32'hFF);
    chk("rd_underrun", 32'(underrun), 32'(exp_underrun));
    cs_release();
    chk("rd_start_once", 32'(st_cnt - st0), 1);
    chk("rd_no_coincidence", 32'(coinc), 0);
    chk("rd_idle_byte", 32'(tx_byte), 32'hFF);

    // Overflow: plug stalls, second word dropped, held word survives cs.
    rx_ready = 1'b0;
    w1 = $urandom; w2 = $urandom;
    cs_assert();
    send_byte(8'h02);
    send_addr($urandom);
    for (int b = 0; b < 4; b++) send_byte(w1[8*b +: 8]);
    chk("ovf_first_valid", 32'(rx_valid), 1);
    chk("ovf_no_flag_yet", 32'(overflow), 0);
    for (int b = 0; b < 4; b++) send_byte(w2[8*b +: 8]);
    exp_overflow = 1'b1;
    chk("ovf_flag", 32'(overflow), 32'(exp_overflow));
    chk("ovf_held_word", rx_data, w1);
    cs_release();
    chk("ovf_valid_after_cs", 32'(rx_valid), 1);
    exp_q.push_back(w1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovf_drained", 32'(rx_valid), 0);
    check_words("ovf");
    chk("ovf_sticky", 32'(overflow), 1);

    // Partial write discarded, then SET_WRAP frames decode cleanly.
    cs_assert();
    send_byte(8'h02);
    send_addr($urandom);
    send_byte(8'hAA);
    send_byte(8'h55);
    cs_release();
    repeat (2) @(posedge clk);
    #1 chk("partial_no_valid", 32'(rx_valid), 0);
    check_words("partial");
    for (int k = 0; k < 2; k++) begin
      wl = (k == 0) ? 16'h0008 : 16'($urandom_range(1, 65535));
      cs_assert();
      send_byte(8'h11);
      send_byte(wl[15:8]);
      send_byte(wl[7:0]);
      chk("wrap_length", 32'(wrap_length), 32'(wl));
      send_byte(8'h77);
      chk("wrap_ignore_tail", 32'(wrap_length), 32'(wl));
      cs_release();
    end

    // cs rising together with a byte strobe: the byte must be ignored.
    cs_assert();
    send_byte(8'h11);
    send_byte(8'h12);
    @(posedge clk); #1 cs = 1'b1; rx_byte = 8'h34; rx_byte_valid = 1'b1;
    @(posedge clk); #1 rx_byte_valid = 1'b0;
    @(posedge clk); #1;
    chk("cs_wins_wrap", 32'(wrap_length), 32'(wl));

`ifdef SPI_CMD_STATUS_EN
    cs_assert();
    send_byte(8'h05);
    chk("status_byte", 32'(tx_byte), {30'b0, exp_underrun, exp_overflow});
    tx_req();
    exp_overflow = 1'b0; exp_underrun = 1'b0;
    chk("status_clr_ovf", 32'(overflow), 32'(exp_overflow));
    chk("status_clr_udr", 32'(underrun), 32'(exp_underrun));
    chk("status_then_idle", 32'(tx_byte), 32'hFF);
    cs_release();
`else
    av0 = av_cnt;
    cs_assert();
    send_byte(8'h05);
    send_addr($urandom);
    chk("op05_idle_byte", 32'(tx_byte), 32'hFF);
    chk("op05_no_addr", 32'(av_cnt - av0), 0);
    cs_release();
    chk("op05_flags_kept", {30'b0, underrun, overflow}, {30'b0, exp_underrun, exp_overflow});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
